// File: rtl/smux_pkg.sv
// Shared definitions for the sequenced round-data selector.
//   state_e      : sequencer states (IDLE, RUN)
//   MODE_*       : selection modes latched when a sequence starts
//   DEF_*        : default geometry used by smux_seq and smux_sel
package smux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_STAGED = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEF_WIDTH  = 136;
  localparam int DEF_NUM_CH = 3;
  localparam int DEF_ROUNDS = 16;

endpackage

// File: rtl/smux_sel.sv
// Combinational channel selector.
//   data_in  : NUM_CH packed channels, channel k at [k*WIDTH +: WIDTH]
//   mode     : MODE_STAGED or MODE_RR
//   counter  : current round index (used in staged mode)
//   rr_idx   : counter mod NUM_CH, kept as its own register by the caller
//   sel_data : the selected channel
module smux_sel
  import smux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int CNT_W  = $clog2(ROUNDS),
  parameter int RR_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic                    mode,
  input  logic [CNT_W-1:0]        counter,
  input  logic [RR_W-1:0]         rr_idx,
  output logic [WIDTH-1:0]        sel_data
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of inferred latches.
    sel_data = data_in[0 +: WIDTH];
    if (mode == MODE_RR) begin
      // rr_idx never exceeds NUM_CH-1, so exactly one arm matches.
      for (int k = 0; k < NUM_CH; k++) begin
        if (rr_idx == RR_W'(k)) sel_data = data_in[k*WIDTH +: WIDTH];
      end
    end else if (counter == LAST_RND) begin
      sel_data = data_in[(NUM_CH-1)*WIDTH +: WIDTH];
    end else if (counter != '0) begin
      sel_data = data_in[WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/smux_seq.sv
// Sequenced round-data selector with valid/ready on both sides.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, mux_flag     : begin a sequence (IDLE only) and its selection mode
//   data_in, in_valid   : packed channels offered for the current round
//   in_ready            : input accepted this cycle when in_valid is also high
//   data_out, out_valid : registered selected channel
//   out_ready           : downstream takes data_out
//   counter             : round index of the next input to be accepted
//   last                : data_out belongs to the final round (qualified by out_valid)
//   busy                : sequence in progress
module smux_seq
  import smux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int CNT_W  = $clog2(ROUNDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mux_flag,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        counter,
  output logic                    last,
  output logic                    busy
);

  localparam int               RR_W     = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);
  localparam logic [RR_W-1:0]  LAST_RR  = RR_W'(NUM_CH - 1);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [RR_W-1:0]    rr_idx_q, rr_idx_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               out_valid_q, out_valid_d;
  logic               last_q, last_d;
  logic               accept;
  logic [WIDTH-1:0]   sel_data;

  // The output register is free when empty or being drained this cycle.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  smux_sel #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .ROUNDS (ROUNDS),
    .CNT_W  (CNT_W),
    .RR_W   (RR_W)
  ) u_sel (
    .data_in  (data_in),
    .mode     (mode_q),
    .counter  (counter_q),
    .rr_idx   (rr_idx_q),
    .sel_data (sel_data)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    counter_d   = counter_q;
    rr_idx_d    = rr_idx_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;

    // A drain clears the output; an accept below re-fills it in the same cycle.
    if (out_ready) out_valid_d = 1'b0;

    if (accept) begin
      data_out_d  = sel_data;
      out_valid_d = 1'b1;
      last_d      = (counter_q == LAST_RND);
      if (counter_q == LAST_RND) begin
        counter_d = '0;
        rr_idx_d  = '0;
        state_d   = IDLE;
      end else begin
        counter_d = counter_q + 1'b1;
        rr_idx_d  = (rr_idx_q == LAST_RR) ? '0 : rr_idx_q + 1'b1;
      end
    end

    // accept is impossible in IDLE, so this never collides with the block above.
    if (state_q == IDLE && start) begin
      state_d   = RUN;
      mode_d    = mux_flag;
      counter_d = '0;
      rr_idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= MODE_STAGED;
      counter_q   <= '0;
      rr_idx_q    <= '0;
      // NOTE: the data register is reset too, because data_out must read 0 after reset,
      // not merely be marked invalid.
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      counter_q   <= counter_d;
      rr_idx_q    <= rr_idx_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign counter   = counter_q;
  assign last      = last_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_smux_seq.sv
// Self-checking bench for smux_seq. Three instances: default geometry
// (directed scenarios plus random traffic) and two WIDTH=8 sweeps
// (NUM_CH=2/ROUNDS=4 and NUM_CH=5/ROUNDS=10). Each instance has a
// behavioural model that tracks round number, mode and the pending
// output word, and compares all outputs on every falling edge.
module tb_smux_seq;

  logic clk;
  logic rst_n;
  logic start_a     [3];
  logic mux_flag_a  [3];
  logic in_valid_a  [3];
  logic out_ready_a [3];
  logic [407:0] din_a [3];

  int n_checks;
  int n_fail;
  bit mon_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Channel chosen for a round, straight from the mode rules.
  function automatic int exp_ch(bit mode, int round, int nc, int rn);
    if (mode) return round % nc;
    if (round == 0) return 0;
    if (round == rn - 1) return nc - 1;
    return 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int NC = (g == 0) ? 3 : (g == 1) ? 2 : 5;
    localparam int RN = (g == 0) ? 16 : (g == 1) ? 4 : 10;
    localparam int W  = (g == 0) ? 136 : 8;
    localparam int CW = $clog2(RN);

    logic [NC*W-1:0] din;
    logic            in_ready;
    logic [W-1:0]    dout;
    logic            out_valid;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            busy;

    assign din = din_a[g][NC*W-1:0];

    smux_seq #(
      .WIDTH  (W),
      .NUM_CH (NC),
      .ROUNDS (RN)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_a[g]),
      .mux_flag  (mux_flag_a[g]),
      .data_in   (din),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready),
      .data_out  (dout),
      .out_valid (out_valid),
      .out_ready (out_ready_a[g]),
      .counter   (cnt),
      .last      (last),
      .busy      (busy)
    );

    // Model state
    bit           m_run;
    bit           m_mode;
    bit           m_pend;
    bit           m_last;
    int           m_round;
    logic [W-1:0] m_data;
    int           m_lasts;

    always @(negedge clk) begin
      bit rdy;
      bit acc;
      bit was_run;
      int ch;
      rdy = m_run && (!m_pend || out_ready_a[g]);
      if (mon_en) begin
        check($sformatf("g%0d_in_ready", g), in_ready, rdy);
        check($sformatf("g%0d_busy", g), busy, m_run);
        check($sformatf("g%0d_out_valid", g), out_valid, m_pend);
        check($sformatf("g%0d_counter", g), cnt, m_round);
        if (m_pend) begin
          check($sformatf("g%0d_data_out r%0d", g, m_round), dout, m_data);
          check($sformatf("g%0d_last", g), last, m_last);
        end
        if (!rst_n) check($sformatf("g%0d_data_rst", g), dout, m_data);
      end
      // Advance the model using the inputs the DUT will sample at the next edge.
      was_run = m_run;
      if (!rst_n) begin
        m_run = 0; m_mode = 0; m_pend = 0; m_last = 0; m_round = 0; m_data = '0;
      end else begin
        acc = in_valid_a[g] && rdy;
        if (acc) begin
          ch     = exp_ch(m_mode, m_round, NC, RN);
          m_data = din[ch*W +: W];
          m_last = (m_round == RN - 1);
          m_pend = 1;
          if (m_round == RN - 1) begin
            m_round = 0;
            m_run   = 0;
            m_lasts++;
          end else begin
            m_round++;
          end
        end else if (out_ready_a[g]) begin
          m_pend = 0;
        end
        if (!was_run && start_a[g]) begin
          m_run   = 1;
          m_round = 0;
          m_mode  = mux_flag_a[g];
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_seq(input int g, input bit mode, input int n);
    start_a[g] = 1; mux_flag_a[g] = mode;
    cyc(1);
    start_a[g] = 0; in_valid_a[g] = 1; out_ready_a[g] = 1;
    cyc(n);
    in_valid_a[g] = 0;
    cyc(2);
  endtask

  task automatic rand_data(input int g);
    for (int b = 0; b < 51; b++) din_a[g][b*8 +: 8] = 8'($urandom);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 0;
    rst_n    = 0;
    for (int g = 0; g < 3; g++) begin
      start_a[g] = 0; mux_flag_a[g] = 0; in_valid_a[g] = 0; out_ready_a[g] = 0;
      din_a[g] = '0;
    end
    din_a[0] = {{17{8'h03}}, {17{8'h02}}, {17{8'h01}}};
    cyc(1);
    mon_en = 1;
    cyc(1);
    rst_n = 1;
    cyc(1);

    // Staged and round-robin, full throughput
    run_seq(0, 0, 18);
    run_seq(0, 1, 18);
    if (g_inst[0].m_lasts != 2) check("seq_count_a", 136'(g_inst[0].m_lasts), 136'd2);

    // Backpressure after round 3
    start_a[0] = 1; mux_flag_a[0] = 0;
    cyc(1);
    start_a[0] = 0; in_valid_a[0] = 1; out_ready_a[0] = 1;
    cyc(4);
    out_ready_a[0] = 0;
    cyc(5);
    out_ready_a[0] = 1;
    cyc(16);
    in_valid_a[0] = 0;
    cyc(2);

    // Mode toggling and a start pulse mid-sequence
    start_a[0] = 1; mux_flag_a[0] = 0;
    cyc(1);
    start_a[0] = 0; in_valid_a[0] = 1; out_ready_a[0] = 1;
    for (int i = 0; i < 20; i++) begin
      mux_flag_a[0] = i[0];
      start_a[0]    = (i == 7);
      cyc(1);
    end
    start_a[0] = 0; in_valid_a[0] = 0;
    cyc(2);

    // Reset at round 9 with output pending, then restart
    start_a[0] = 1; mux_flag_a[0] = 1;
    cyc(1);
    start_a[0] = 0; in_valid_a[0] = 1; out_ready_a[0] = 1;
    cyc(10);
    rst_n = 0;
    cyc(1);
    rst_n = 1; in_valid_a[0] = 0;
    cyc(1);
    run_seq(0, 0, 18);

    // Parameter sweep instances, both modes
    for (int g = 1; g < 3; g++) begin
      rand_data(g);
      run_seq(g, 0, 12);
      rand_data(g);
      run_seq(g, 1, 12);
    end

    // Random traffic on all instances
    for (int i = 0; i < 3000; i++) begin
      for (int g = 0; g < 3; g++) begin
        start_a[g]     = ($urandom_range(0, 3) == 0);
        mux_flag_a[g]  = 1'($urandom);
        in_valid_a[g]  = ($urandom_range(0, 3) != 0);
        out_ready_a[g] = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 3) == 0) rand_data(g);
      end
      rst_n = ($urandom_range(0, 399) != 0);
      cyc(1);
    end
    rst_n = 1;
    for (int g = 0; g < 3; g++) begin
      start_a[g] = 0; in_valid_a[g] = 0; out_ready_a[g] = 1;
    end
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smux_seq.md
Name: smux_seq

Overview:
- Sequenced, parametrised round-data selector with a registered output and valid/ready handshakes on input and output.
- It selects one of NUM_CH WIDTH-bit input channels per round, using a latched mode and an internal round counter that runs from 0 to ROUNDS-1.
- It sits between the round-key/state sources and the round datapath, replacing external counter-driven combinational selection.
- It adds backpressure, a round-robin mode and an end-of-sequence indication.

Parameters:
- WIDTH, 136, bit width of each channel and of data_out.
- NUM_CH, 3, number of input channels (minimum 2).
- ROUNDS, 16, rounds per sequence (minimum 2).
- CNT_W, $clog2(ROUNDS), round counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  begin a sequence; honoured only in IDLE.
- mux_flag  in  1  mode, sampled when start is accepted: 0 = staged, 1 = round-robin.
- data_in  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  1  data_in is valid.
- in_ready  out  1  block accepts data_in this cycle.
- data_out  out  WIDTH  registered selected channel.
- out_valid  out  1  data_out is valid.
- out_ready  in  1  downstream accepts data_out.
- counter  out  CNT_W  round index of the next input to be accepted.
- last  out  1  data_out holds round ROUNDS-1; qualified by out_valid.
- busy  out  1  high in RUN.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; data_out, out_valid, counter, last, busy, in_ready and the mode register all 0.
- States and transitions:
  - IDLE -> RUN on start: counter <= 0, mode <= mux_flag.
  - RUN -> IDLE on acceptance of round ROUNDS-1.
  - start in RUN is ignored.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational from state and out_valid/out_ready only; never depends on in_valid.
- Input accept (in_valid && in_ready):
  - data_out <= selected channel; out_valid <= 1.
  - last <= (counter==ROUNDS-1).
  - counter increments. On round ROUNDS-1 it wraps to 0 and the state returns to IDLE.
- Output handshake:
  - out_valid drops when out_ready is high and no new accept occurs in the same cycle.
  - Simultaneous output drain and input accept gives back-to-back throughput of one round per cycle.
  - data_out and last are stable while out_valid && !out_ready.
- Latency: 1 cycle from input accept to out_valid.
- Selection, mode 0 (staged): round 0 -> ch0; rounds 1..ROUNDS-2 -> ch1; round ROUNDS-1 -> ch NUM_CH-1.
- Selection, mode 1 (round-robin): channel = counter mod NUM_CH. Use a separate modulo-NUM_CH index register that resets to 0 with counter; no divider.
- The mode is fixed for the whole sequence; changing mux_flag in RUN has no effect.
- After the final round: the final word stays in the output register with last=1 until drained, while the state is already IDLE.
  - A start in that cycle or later is honoured.
  - in_ready stays low until the state is RUN and the output register is free.
- Reset mid-sequence: next cycle is IDLE with all outputs 0; any pending output is discarded.
- in_valid without in_ready: no state change; data_in is not captured.

Decomposition:
- Shared package smux_pkg holds:
  - state typedef (IDLE, RUN);
  - mode constants MODE_STAGED=0 and MODE_RR=1;
  - default WIDTH/NUM_CH/ROUNDS.
- One natural sub-module, smux_sel: a purely combinational channel selector with inputs data_in, mode, counter and rr_idx, and output sel_data. The FSM, counters and output register stay in smux_seq.

Test Plan:
1. Reset then start with mux_flag=0 and all channels distinct, with ch0=136'h01..., ch1=136'h02..., ch2=136'h03... and in_valid and out_ready held high -> 16 outputs on consecutive cycles: ch0, 14x ch1, then ch2 with last=1; busy falls after the 16th accept.
2. mux_flag=1, same stimulus -> channels 0,1,2,0,1,2,...,0 over rounds 0..15; round 15 selects ch0 (15 mod 3 = 0) with last=1.
3. Mode 0 with out_ready low for 5 cycles after round 3 -> data_out holds the round-3 value; in_ready low; counter stays 4; traffic resumes with no lost or duplicated round.
4. Toggle mux_flag mid-sequence, and pulse start at round 7 -> selection is unchanged, counter is unaffected, and the sequence completes normally.
5. rst_n low at round 9 while out_valid=1 -> next cycle out_valid=0, counter=0, busy=0; a subsequent start restarts from round 0.
6. Parameter sweep NUM_CH=2/ROUNDS=4 and NUM_CH=5/ROUNDS=10, WIDTH=8 -> selection matches both mode rules; counter wraps at ROUNDS-1; last is asserted exactly once per sequence.
